// File: rtl/vim828_pkg.sv
// Shared definitions for the VIM828 text-layer stage: control codes,
// FSM state encoding and frame geometry.
package vim828_pkg;

    localparam int TEXT_W = 64;

    localparam logic [7:0] CC_BS  = 8'h08;
    localparam logic [7:0] CC_LF  = 8'h0A;
    localparam logic [7:0] CC_FF  = 8'h0C;
    localparam logic [7:0] CC_CR  = 8'h0D;
    localparam logic [7:0] CC_ESC = 8'h1B;
    localparam logic [7:0] CC_DOT = 8'h2E;

    typedef enum logic {
        IDLE   = 1'b0,
        ESCAPE = 1'b1
    } state_t;

endpackage

// File: rtl/vim828_char_buffer.sv
// Character buffer between UART RX and the 14-segment decode path.
// Ports: Clock, Reset (async low), RxDone_i/RxByte_i byte strobe in;
// Text_o 8-char frame (Char0 newest, bits [7:0]), Points_o DP mask,
// Update_o one-cycle frame-changed pulse, Escape_o escape pending.
import vim828_pkg::*;

module vim828_char_buffer #(
    parameter bit         NEWLINE_CLEARS = 1'b1,
    parameter bit         DP_MERGE       = 1'b1,
    parameter logic [7:0] BLANK          = 8'h20
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              RxDone_i,
    input  logic [7:0]        RxByte_i,
    output logic [TEXT_W-1:0] Text_o,
    output logic [7:0]        Points_o,
    output logic              Update_o,
    output logic              Escape_o
);

    localparam logic [TEXT_W-1:0] BLANK_FRAME = {8{BLANK}};

    state_t state;
    logic   pending;
    logic   attach;

    logic              is_dot;
    logic              is_print;
    logic              is_nl;
    logic              is_bs;
    logic              is_ff;
    logic              is_esc;
    logic [TEXT_W-1:0] shifted;
    logic [TEXT_W-1:0] fresh;

    always_comb begin
        is_dot   = DP_MERGE && (RxByte_i == CC_DOT);
        is_print = (RxByte_i >= 8'h20) && (RxByte_i <= 8'h7E)
                   && !is_dot;
        is_nl    = (RxByte_i == CC_LF) || (RxByte_i == CC_CR);
        is_bs    = (RxByte_i == CC_BS);
        is_ff    = (RxByte_i == CC_FF);
        is_esc   = (RxByte_i == CC_ESC);
        shifted  = {Text_o[TEXT_W-9:0], RxByte_i};
        // Frame after a deferred clear followed by the new character.
        fresh    = {BLANK_FRAME[TEXT_W-1:8], RxByte_i};
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state    <= IDLE;
            pending  <= 1'b0;
            attach   <= 1'b0;
            Text_o   <= BLANK_FRAME;
            Points_o <= 8'h00;
            Update_o <= 1'b0;
            Escape_o <= 1'b0;
        end else begin
            Update_o <= 1'b0;
            if (RxDone_i) begin
                unique case (state)
                    ESCAPE: begin
                        Text_o   <= pending ? fresh : shifted;
                        Points_o <= pending ? 8'h00
                                            : {Points_o[6:0], 1'b0};
                        attach   <= 1'b1;
                        pending  <= 1'b0;
                        Update_o <= 1'b1;
                        state    <= IDLE;
                        Escape_o <= 1'b0;
                    end
                    IDLE: begin
                        unique case (1'b1)
                            is_print: begin
                                Text_o   <= pending ? fresh : shifted;
                                Points_o <= pending ? 8'h00
                                                    : {Points_o[6:0], 1'b0};
                                attach   <= 1'b1;
                                pending  <= 1'b0;
                                Update_o <= 1'b1;
                            end
                            is_dot: begin
                                if (pending) begin
                                    Text_o   <= BLANK_FRAME;
                                    Points_o <= 8'h01;
                                end else if (attach && !Points_o[0]) begin
                                    // DP lands on the character already shown.
                                    Points_o[0] <= 1'b1;
                                end else begin
                                    Text_o   <= {Text_o[TEXT_W-9:0], BLANK};
                                    Points_o <= {Points_o[6:0], 1'b1};
                                end
                                attach   <= 1'b0;
                                pending  <= 1'b0;
                                Update_o <= 1'b1;
                            end
                            is_bs: begin
                                Text_o   <= {BLANK, Text_o[TEXT_W-1:8]};
                                Points_o <= {1'b0, Points_o[7:1]};
                                attach   <= 1'b0;
                                pending  <= 1'b0;
                                Update_o <= 1'b1;
                            end
                            is_nl: begin
                                if (NEWLINE_CLEARS) begin
                                    pending <= 1'b1;
                                end
                            end
                            is_ff: begin
                                Text_o   <= BLANK_FRAME;
                                Points_o <= 8'h00;
                                attach   <= 1'b0;
                                pending  <= 1'b0;
                                Update_o <= 1'b1;
                            end
                            is_esc: begin
                                state    <= ESCAPE;
                                Escape_o <= 1'b1;
                            end
                            default: begin
                            end
                        endcase
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vim828_char_buffer.sv
// Self-checking bench for vim828_char_buffer: directed scenarios plus
// randomized byte streams compared against an array-based text model.
module tb_vim828_char_buffer;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        RxDone_i;
    logic [7:0]  RxByte_i;
    logic [63:0] Text_o;
    logic [7:0]  Points_o;
    logic        Update_o;
    logic        Escape_o;

    int checks = 0;
    int errors = 0;

    logic [7:0] m_ch [8];
    bit         m_dp [8];
    bit         m_pend;
    bit         m_att;
    bit         m_esc;
    bit         m_upd;

    vim828_char_buffer dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .RxDone_i (RxDone_i),
        .RxByte_i (RxByte_i),
        .Text_o   (Text_o),
        .Points_o (Points_o),
        .Update_o (Update_o),
        .Escape_o (Escape_o)
    );

    always #5 Clock = ~Clock;

    function automatic logic [63:0] m_text();
        logic [63:0] t;
        for (int i = 0; i < 8; i++) t[8*i +: 8] = m_ch[i];
        return t;
    endfunction

    function automatic logic [7:0] m_points();
        logic [7:0] p;
        for (int i = 0; i < 8; i++) p[i] = m_dp[i];
        return p;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 8; i++) begin
            m_ch[i] = 8'h20;
            m_dp[i] = 1'b0;
        end
    endtask

    task automatic m_reset();
        m_clear();
        m_pend = 0;
        m_att  = 0;
        m_esc  = 0;
        m_upd  = 0;
    endtask

    task automatic m_shift(input logic [7:0] x, input bit d);
        for (int i = 7; i > 0; i--) begin
            m_ch[i] = m_ch[i-1];
            m_dp[i] = m_dp[i-1];
        end
        m_ch[0] = x;
        m_dp[0] = d;
    endtask

    task automatic m_apply(input logic [7:0] b);
        m_upd = 0;
        if (m_esc) begin
            if (m_pend) m_clear();
            m_shift(b, 0);
            m_att = 1; m_pend = 0; m_upd = 1; m_esc = 0;
        end else if (b == 8'h1B) begin
            m_esc = 1;
        end else if (b == 8'h0A || b == 8'h0D) begin
            m_pend = 1;
        end else if (b == 8'h0C) begin
            m_clear();
            m_pend = 0; m_att = 0; m_upd = 1;
        end else if (b == 8'h08) begin
            for (int i = 0; i < 7; i++) begin
                m_ch[i] = m_ch[i+1];
                m_dp[i] = m_dp[i+1];
            end
            m_ch[7] = 8'h20;
            m_dp[7] = 0;
            m_att = 0; m_pend = 0; m_upd = 1;
        end else if (b == 8'h2E) begin
            if (m_pend) begin
                m_clear();
                m_dp[0] = 1;
            end else if (m_att && !m_dp[0]) begin
                m_dp[0] = 1;
            end else begin
                m_shift(8'h20, 1);
            end
            m_att = 0; m_pend = 0; m_upd = 1;
        end else if (b >= 8'h20 && b <= 8'h7E) begin
            if (m_pend) m_clear();
            m_shift(b, 0);
            m_att = 1; m_pend = 0; m_upd = 1;
        end
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic send(input logic [7:0] b);
        RxByte_i = b;
        RxDone_i = 1'b1;
        m_apply(b);
        @(posedge Clock);
        @(negedge Clock);
        RxDone_i = 1'b0;
    endtask

    task automatic do_reset();
        RxDone_i = 1'b0;
        RxByte_i = 8'h00;
        Reset    = 1'b0;
        m_reset();
        @(negedge Clock);
        @(negedge Clock);
        Reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (Text_o !== {8{8'h20}}) begin
            errors++;
            $display("FAIL reset_text: got %h expected %h",
                     Text_o, {8{8'h20}});
        end
        checks++;
        if (Points_o !== 8'h00) begin
            errors++;
            $display("FAIL reset_points: got %h expected 00", Points_o);
        end
        checks++;
        if (Update_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_update: got %b expected 0", Update_o);
        end
        checks++;
        if (Escape_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_escape: got %b expected 0", Escape_o);
        end
    endtask

    task automatic test_shift();
        logic [7:0] s [9];
        s = '{"1", "2", "3", "4", "5", "6", "7", "8", "9"};
        for (int i = 0; i < 9; i++) begin
            send(s[i]);
            checks++;
            if (Update_o !== 1'b1) begin
                errors++;
                $display("FAIL shift_update[%0d]: got %b expected 1",
                         i, Update_o);
            end
        end
        checks++;
        if (Text_o !== "23456789") begin
            errors++;
            $display("FAIL shift_text: got %h expected %h",
                     Text_o, "23456789");
        end
        checks++;
        if (Points_o !== 8'h00) begin
            errors++;
            $display("FAIL shift_points: got %h expected 00", Points_o);
        end
        @(negedge Clock);
        checks++;
        if (Update_o !== 1'b0) begin
            errors++;
            $display("FAIL shift_pulse_width: got %b expected 0", Update_o);
        end
    endtask

    task automatic test_dp();
        send("3"); send("."); send("1"); send("4");
        checks++;
        if (Text_o[23:0] !== "314" || Points_o !== 8'h04) begin
            errors++;
            $display("FAIL dp_314: got %h/%h expected 333134/04",
                     Text_o[23:0], Points_o);
        end
        send(".");
        checks++;
        if (Points_o !== 8'h05 || Text_o[7:0] !== "4") begin
            errors++;
            $display("FAIL dp_attach: got %h/%h expected 05/34",
                     Points_o, Text_o[7:0]);
        end
        send(".");
        checks++;
        if (Points_o !== 8'h0B || Text_o[15:0] !== "4 ") begin
            errors++;
            $display("FAIL dp_blank: got %h/%h expected 0b/3420",
                     Points_o, Text_o[15:0]);
        end
        checks++;
        if (Text_o !== m_text() || Points_o !== m_points()) begin
            errors++;
            $display("FAIL dp_model: got %h/%h expected %h/%h",
                     Text_o, Points_o, m_text(), m_points());
        end
    endtask

    task automatic test_newline();
        logic [63:0] saved;
        send("A"); send("B");
        saved = Text_o;
        send(8'h0D);
        checks++;
        if (Update_o !== 1'b0 || Text_o !== saved) begin
            errors++;
            $display("FAIL nl_cr: got upd=%b %h expected upd=0 %h",
                     Update_o, Text_o, saved);
        end
        send(8'h0A);
        checks++;
        if (Update_o !== 1'b0 || Text_o !== saved) begin
            errors++;
            $display("FAIL nl_lf: got upd=%b %h expected upd=0 %h",
                     Update_o, Text_o, saved);
        end
        send("C");
        checks++;
        if (Text_o !== "       C" || Points_o !== 8'h00) begin
            errors++;
            $display("FAIL nl_clear: got %h/%h expected %h/00",
                     Text_o, Points_o, "       C");
        end
    endtask

    task automatic test_bs_ff();
        send("X"); send("Y"); send("Z"); send(8'h08);
        checks++;
        if (Text_o[15:0] !== "XY" || Text_o[63:56] !== 8'h20) begin
            errors++;
            $display("FAIL bs_text: got %h expected ..XY, char7 20",
                     Text_o);
        end
        checks++;
        if (Update_o !== 1'b1) begin
            errors++;
            $display("FAIL bs_update: got %b expected 1", Update_o);
        end
        send(8'h0C);
        checks++;
        if (Text_o !== {8{8'h20}} || Points_o !== 8'h00) begin
            errors++;
            $display("FAIL ff_clear: got %h/%h expected blank/00",
                     Text_o, Points_o);
        end
        send(8'h08);
        checks++;
        if (Text_o !== {8{8'h20}} || Update_o !== 1'b1) begin
            errors++;
            $display("FAIL bs_empty: got %h upd=%b expected blank upd=1",
                     Text_o, Update_o);
        end
    endtask

    task automatic test_escape();
        logic [7:0] prev;
        send("K");
        prev = Text_o[7:0];
        send(8'h1B);
        checks++;
        if (Escape_o !== 1'b1 || Update_o !== 1'b0) begin
            errors++;
            $display("FAIL esc_enter: got esc=%b upd=%b expected 1/0",
                     Escape_o, Update_o);
        end
        send(8'h0C);
        checks++;
        if (Text_o[15:0] !== {prev, 8'h0C} || Escape_o !== 1'b0
            || Update_o !== 1'b1) begin
            errors++;
            $display("FAIL esc_raw: got %h esc=%b upd=%b expected %h0c 0 1",
                     Text_o[15:0], Escape_o, Update_o, prev);
        end
        send(8'h07);
        checks++;
        if (Update_o !== 1'b0 || Text_o !== m_text()) begin
            errors++;
            $display("FAIL ignore_bel: got upd=%b %h expected 0 %h",
                     Update_o, Text_o, m_text());
        end
    endtask

    task automatic test_reset_escape();
        send("R");
        send(8'h1B);
        Reset = 1'b0;
        m_reset();
        #1;
        checks++;
        if (Escape_o !== 1'b0 || Text_o !== {8{8'h20}}) begin
            errors++;
            $display("FAIL rst_esc: got esc=%b %h expected 0 blank",
                     Escape_o, Text_o);
        end
        @(negedge Clock);
        Reset = 1'b1;
        send("Q");
        send(8'h0C);
        checks++;
        if (Text_o !== {8{8'h20}} || Update_o !== 1'b1
            || Escape_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_esc_ff: got %h upd=%b esc=%b expected FF",
                     Text_o, Update_o, Escape_o);
        end
    endtask

    task automatic test_random();
        logic [7:0] b;
        logic [7:0] ctl [5];
        ctl = '{8'h08, 8'h0A, 8'h0D, 8'h0C, 8'h1B};
        for (int i = 0; i < 500; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 9: b = 8'($urandom_range(8'h20, 8'h7E));
                5, 8:          b = 8'h2E;
                6:             b = ctl[$urandom_range(0, 4)];
                default:       b = 8'($urandom_range(0, 255));
            endcase
            send(b);
            checks++;
            if (Text_o !== m_text() || Points_o !== m_points()
                || Update_o !== m_upd || Escape_o !== m_esc) begin
                errors++;
                $display("FAIL random[%0d] byte %h: got %h/%h/%b/%b expected %h/%h/%b/%b",
                         i, b, Text_o, Points_o, Update_o, Escape_o,
                         m_text(), m_points(), m_upd, m_esc);
            end
            if ($urandom_range(0, 3) == 0) begin
                @(negedge Clock);
                checks++;
                if (Update_o !== 1'b0) begin
                    errors++;
                    $display("FAIL random_gap[%0d]: got %b expected 0",
                             i, Update_o);
                end
            end
        end
    endtask

    initial begin
        Reset    = 1'b0;
        RxDone_i = 1'b0;
        RxByte_i = 8'h00;
        m_reset();
        @(negedge Clock);
        test_reset();
        test_shift();
        test_dp();
        test_newline();
        test_bs_ff();
        test_escape();
        test_reset_escape();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
